// File: rtl/watch_pkg.sv
// Shared definitions for the watch sequencing controller: the time-set FSM
// encoding and a small elaboration-time helper.
package watch_pkg;

  typedef logic [1:0] state_t;

  localparam state_t RUN      = 2'b00;
  localparam state_t SET_HOUR = 2'b01;
  localparam state_t SET_MIN  = 2'b10;
  localparam state_t SET_SEC  = 2'b11;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/watch_ctrl_btn_sync_edge.sv
// Two-flop synchronizer for a debounced front-panel button, plus a
// previous-value flop that turns the synchronized level into a press pulse.
module btn_sync_edge (
  input  logic CLK,
  input  logic RST,
  input  logic btn,
  output logic sync2,
  output logic press
);

  logic sync1;
  logic prev;

  // All three flops clear on reset, so a button held through reset still
  // produces exactly one press once it is seen low-to-high afterwards.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign press = sync2 & ~prev;

endmodule

// File: rtl/watch_ctrl.sv
// Sequencing controller for the watch counter chain: 1 Hz seconds enable,
// run-mode carry gating and the button-driven time-set FSM with auto-repeat.
module watch_ctrl
  import watch_pkg::*;
#(
  parameter int DIV        = 50_000_000,
  parameter int REPEAT_DLY = 25_000_000,
  parameter int REPEAT_PER = 10_000_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN_MODE,
  input  logic       BTN_UP,
  input  logic       SEC_CA,
  input  logic       MIN_CA,
  output logic       SEC_EN,
  output logic       SEC_CLR,
  output logic       MIN_EN,
  output logic       MIN_INC,
  output logic       HOUR_EN,
  output logic       HOUR_INC,
  output logic [1:0] MODE_STATE,
  output logic       BLINK
);

  localparam int PW = $clog2(DIV);
  localparam int HW = $clog2(max_int(REPEAT_DLY, REPEAT_PER) + 1);

  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] PRE_HALF = PW'(DIV / 2);
  localparam logic [PW-1:0] PRE_ONE  = PW'(1);
  localparam logic [HW-1:0] DLY_CNT  = HW'(REPEAT_DLY);
  localparam logic [HW-1:0] PER_CNT  = HW'(REPEAT_PER);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);

  state_t          state;
  logic [PW-1:0]   prescaler;
  logic [HW-1:0]   hold_cnt;
  logic            repeating;
  logic            mode_press;
  logic            mode_level_unused;
  logic            up_press;
  logic            up_level;
  logic            in_inc_state;
  logic            repeat_fire;
  logic            step;

  btn_sync_edge u_mode_sync (
    .CLK   (CLK),
    .RST   (RST),
    .btn   (BTN_MODE),
    .sync2 (mode_level_unused),
    .press (mode_press)
  );

  btn_sync_edge u_up_sync (
    .CLK   (CLK),
    .RST   (RST),
    .btn   (BTN_UP),
    .sync2 (up_level),
    .press (up_press)
  );

  // The hold counter is 1 in the cycle of the first increment pulse, so a
  // match on the delay/period value lands the next pulse exactly that far out.
  always_comb begin
    in_inc_state = (state == SET_HOUR) || (state == SET_MIN);
    repeat_fire  = 1'b0;
    if (in_inc_state && up_level && (hold_cnt != '0))
      repeat_fire = repeating ? (hold_cnt == PER_CNT) : (hold_cnt == DLY_CNT);
    step = ~mode_press & (up_press | repeat_fire);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= RUN;
    end else if (mode_press) begin
      state <= state_t'(state + 2'd1);
    end
  end

  // Re-entering RUN restarts the second so the first tick is a full DIV away.
  always_ff @(posedge CLK) begin
    if (RST) begin
      prescaler <= '0;
    end else if ((mode_press && (state == SET_SEC)) || (prescaler == PRE_LAST)) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + PRE_ONE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hold_cnt  <= '0;
      repeating <= 1'b0;
    end else if (mode_press || !up_level || !in_inc_state) begin
      hold_cnt  <= '0;
      repeating <= 1'b0;
    end else if (up_press) begin
      hold_cnt  <= HOLD_ONE;
      repeating <= 1'b0;
    end else if (repeat_fire) begin
      hold_cnt  <= HOLD_ONE;
      repeating <= 1'b1;
    end else if (hold_cnt != '0) begin
      hold_cnt  <= hold_cnt + HOLD_ONE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      SEC_EN   <= 1'b0;
      SEC_CLR  <= 1'b0;
      MIN_INC  <= 1'b0;
      HOUR_INC <= 1'b0;
    end else begin
      SEC_EN   <= (state == RUN) && (prescaler == PRE_LAST);
      SEC_CLR  <= ~mode_press & up_press & (state == SET_SEC);
      MIN_INC  <= step & (state == SET_MIN);
      HOUR_INC <= step & (state == SET_HOUR);
    end
  end

  assign MIN_EN     = SEC_CA & (state == RUN);
  assign HOUR_EN    = MIN_CA & (state == RUN);
  assign MODE_STATE = state;
  assign BLINK      = (state != RUN) && (prescaler < PRE_HALF);

endmodule

// File: tb/tb_watch_ctrl.sv
// Directed self-checking bench for watch_ctrl with short divider and
// auto-repeat constants so every sequence fits in a few hundred cycles.
module tb_watch_ctrl;

  logic       CLK;
  logic       RST;
  logic       BTN_MODE;
  logic       BTN_UP;
  logic       SEC_CA;
  logic       MIN_CA;
  logic       SEC_EN;
  logic       SEC_CLR;
  logic       MIN_EN;
  logic       MIN_INC;
  logic       HOUR_EN;
  logic       HOUR_INC;
  logic [1:0] MODE_STATE;
  logic       BLINK;

  int n_compared   = 0;
  int n_mismatched = 0;
  int cyc          = 0;
  int base         = 0;

  watch_ctrl #(
    .DIV        (10),
    .REPEAT_DLY (20),
    .REPEAT_PER (5)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .BTN_MODE   (BTN_MODE),
    .BTN_UP     (BTN_UP),
    .SEC_CA     (SEC_CA),
    .MIN_CA     (MIN_CA),
    .SEC_EN     (SEC_EN),
    .SEC_CLR    (SEC_CLR),
    .MIN_EN     (MIN_EN),
    .MIN_INC    (MIN_INC),
    .HOUR_EN    (HOUR_EN),
    .HOUR_INC   (HOUR_INC),
    .MODE_STATE (MODE_STATE),
    .BLINK      (BLINK)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_compared++;
    if (got !== want) begin
      n_mismatched++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, want);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick;
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  // Button rises before edge k: state must still be old after edge k+1 and
  // new after edge k+2; then the remaining cycles of a 10-cycle slot are checked.
  task automatic press_mode(input logic [1:0] from_s, input logic [1:0] to_s);
    BTN_MODE = 1'b1;
    tick;
    tick;
    checkOutput("mode_hold", 32'(MODE_STATE), 32'(from_s));
    tick;
    checkOutput("mode_step", 32'(MODE_STATE), 32'(to_s));
    BTN_MODE = 1'b0;
    if (to_s == 2'b00) begin
      base = cyc;
      for (int j = 1; j <= 10; j++) begin
        tick;
        checkOutput("sec_en_first", 32'(SEC_EN), 32'(j == 10));
      end
    end else begin
      for (int j = 0; j < 7; j++) begin
        tick;
        checkOutput("blink", 32'(BLINK), 32'(((cyc - base) % 10) < 5));
        checkOutput("sec_en_set", 32'(SEC_EN), 32'd0);
      end
    end
  endtask

  task automatic applyStimulus;
    logic exp_pulse;

    RST = 1'b1; BTN_MODE = 1'b0; BTN_UP = 1'b0; SEC_CA = 1'b0; MIN_CA = 1'b0;
    tick;
    tick;
    RST = 1'b0;
    cyc = 0;
    base = 0;
    checkOutput("reset_outs",
      32'({SEC_EN, SEC_CLR, MIN_EN, MIN_INC, HOUR_EN, HOUR_INC, BLINK, MODE_STATE}), 32'd0);

    for (int i = 1; i <= 35; i++) begin
      tick;
      checkOutput("run_sec_en", 32'(SEC_EN), 32'(i % 10 == 0));
    end
    checkOutput("run_state", 32'(MODE_STATE), 32'd0);
    checkOutput("run_blink", 32'(BLINK), 32'd0);

    SEC_CA = 1'b1;
    #1;
    checkOutput("run_min_en", 32'(MIN_EN), 32'd1);
    checkOutput("run_hour_en_idle", 32'(HOUR_EN), 32'd0);
    SEC_CA = 1'b0;
    MIN_CA = 1'b1;
    #1;
    checkOutput("run_hour_en", 32'(HOUR_EN), 32'd1);
    MIN_CA = 1'b0;
    tick;

    press_mode(2'b00, 2'b01);
    press_mode(2'b01, 2'b10);
    SEC_CA = 1'b1;
    MIN_CA = 1'b1;
    #1;
    checkOutput("set_min_en", 32'(MIN_EN), 32'd0);
    checkOutput("set_hour_en", 32'(HOUR_EN), 32'd0);
    SEC_CA = 1'b0;
    MIN_CA = 1'b0;
    press_mode(2'b10, 2'b11);
    press_mode(2'b11, 2'b00);

    // Hold UP in SET_MIN: first pulse at t=3, repeats at t+20 then every 5.
    press_mode(2'b00, 2'b01);
    press_mode(2'b01, 2'b10);
    BTN_UP = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      tick;
      if (i == 40) BTN_UP = 1'b0;
      exp_pulse = (i == 3) || (i == 23) || (i == 28) || (i == 33) || (i == 38);
      checkOutput("min_repeat", 32'({HOUR_INC, MIN_INC, SEC_CLR}), 32'({1'b0, exp_pulse, 1'b0}));
    end

    press_mode(2'b10, 2'b11);
    BTN_UP = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick;
      if (i == 25) BTN_UP = 1'b0;
      checkOutput("sec_clr", 32'({HOUR_INC, MIN_INC, SEC_CLR}), 32'({2'b00, i == 3}));
    end

    press_mode(2'b11, 2'b00);
    press_mode(2'b00, 2'b01);
    BTN_MODE = 1'b1;
    BTN_UP = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick;
      if (i == 2) checkOutput("both_hold", 32'(MODE_STATE), 32'd1);
      if (i == 3) begin
        checkOutput("both_step", 32'(MODE_STATE), 32'd2);
        BTN_MODE = 1'b0;
      end
      checkOutput("both_no_inc", 32'({HOUR_INC, MIN_INC, SEC_CLR}), 32'd0);
    end
    BTN_UP = 1'b0;
    for (int i = 0; i < 4; i++) tick;

    // Reset in the middle of an auto-repeat burst in SET_HOUR.
    press_mode(2'b10, 2'b11);
    press_mode(2'b11, 2'b00);
    press_mode(2'b00, 2'b01);
    BTN_UP = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick;
      checkOutput("hour_repeat", 32'({HOUR_INC, MIN_INC, SEC_CLR}),
        32'({(i == 3) || (i == 23) || (i == 28), 2'b00}));
    end
    RST = 1'b1;
    tick;
    RST = 1'b0;
    checkOutput("midrst_outs",
      32'({SEC_EN, SEC_CLR, MIN_EN, MIN_INC, HOUR_EN, HOUR_INC, BLINK, MODE_STATE}), 32'd0);
    for (int j = 1; j <= 15; j++) begin
      tick;
      checkOutput("postrst_quiet", 32'({HOUR_INC, MIN_INC, SEC_CLR, MODE_STATE}), 32'd0);
      checkOutput("postrst_sec_en", 32'(SEC_EN), 32'(j == 10));
    end
    BTN_UP = 1'b0;
    tick;
  endtask

  initial begin
    applyStimulus;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
